// File: rtl/nnrv_id_hs.sv
// nnrv_id_hs: RV32I decode stage with valid/ready on both sides, NUM_FWD-port operand forwarding and branch/jump resolution.
// Latency: one cycle from accepted fetch beat to exec slot; redirect pulse is registered on the same edge.
// Backpressure: o_if_ready drops on an operand hazard or when a full exec slot is not being consumed.
// Ports: i_if_* fetch beat in, o_if_ready/o_if_redirect* back to fetch; o_reg_r* / i_reg_r*_data regfile read;
//        i_fwd_* downstream result ports (index 0 youngest); o_exec_* registered exec slot with i_exec_ready.
module nnrv_id_hs #(
    parameter int XLEN          = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int NUM_FWD       = 2,
    parameter bit RESET_PC_KILL = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_if_valid,
    input  logic [INSTR_WIDTH-1:0]  i_if_instr,
    input  logic [XLEN-1:0]         i_if_pc,
    output logic                    o_if_ready,
    output logic                    o_if_redirect,
    output logic [XLEN-1:0]         o_if_redirect_pc,
    output logic [4:0]              o_reg_r1,
    output logic [4:0]              o_reg_r2,
    input  logic [XLEN-1:0]         i_reg_r1_data,
    input  logic [XLEN-1:0]         i_reg_r2_data,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD-1:0]      i_fwd_ready,
    input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
    output logic                    o_exec_valid,
    input  logic                    i_exec_ready,
    output logic [XLEN-1:0]         o_exec_pc,
    output logic [XLEN-1:0]         o_exec_op1,
    output logic [XLEN-1:0]         o_exec_op2,
    output logic [3:0]              o_exec_type,
    output logic                    o_exec_rd_en,
    output logic [4:0]              o_exec_rd,
    output logic [3:0]              o_exec_ram_mask,
    output logic                    o_exec_sign,
    output logic                    o_exec_illegal
);

    // exec_type codes shared with the nnrv exec stage
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_AND   = 4'd10;
    localparam logic [3:0] OP_LOAD  = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // instruction fields
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic            b30;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm, shamt;

    assign opc   = i_if_instr[6:0];
    assign rd    = i_if_instr[11:7];
    assign f3    = i_if_instr[14:12];
    assign rs1   = i_if_instr[19:15];
    assign rs2   = i_if_instr[24:20];
    assign b30   = i_if_instr[30];
    assign i_imm = XLEN'($signed(i_if_instr[31:20]));
    assign s_imm = XLEN'($signed({i_if_instr[31:25], i_if_instr[11:7]}));
    assign b_imm = XLEN'($signed({i_if_instr[31], i_if_instr[7], i_if_instr[30:25], i_if_instr[11:8], 1'b0}));
    assign j_imm = XLEN'($signed({i_if_instr[31], i_if_instr[19:12], i_if_instr[20], i_if_instr[30:21], 1'b0}));
    assign u_imm = XLEN'($signed({i_if_instr[31:12], 12'b0}));
    assign shamt = XLEN'(rs2);

    assign o_reg_r1 = rs1;
    assign o_reg_r2 = rs2;

    // Returns {stall, value}. Lowest-index ready match wins; a not-ready match
    // at a lower index means the younger value is still in flight, so stall.
    function automatic logic [XLEN:0] fwd_pick(input logic [4:0] src, input logic [XLEN-1:0] rf_dat);
        logic            hit;
        logic            stall;
        logic [XLEN-1:0] val;
        hit   = 1'b0;
        stall = 1'b0;
        val   = rf_dat;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (!hit && i_fwd_valid[k] && (i_fwd_rd[5*k +: 5] == src) && (src != 5'd0)) begin
                if (i_fwd_ready[k]) begin
                    hit = 1'b1;
                    val = i_fwd_data[XLEN*k +: XLEN];
                end else begin
                    stall = 1'b1;
                end
            end
        end
        if (src == 5'd0) val = '0;
        return {stall, val};
    endfunction

    logic [XLEN:0]   pick1, pick2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            use1, use2;

    assign pick1   = fwd_pick(rs1, i_reg_r1_data);
    assign pick2   = fwd_pick(rs2, i_reg_r2_data);
    assign rs1_val = pick1[XLEN-1:0];
    assign rs2_val = pick2[XLEN-1:0];

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (opc)
            OPC_JALR, OPC_LOAD, OPC_OPIMM: use1 = 1'b1;
            OPC_BRANCH, OPC_STORE, OPC_OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: ;
        endcase
    end

    // registered exec slot and control state
    logic            valid_q, rd_en_q, sign_q, ill_q, redirect_q, kill_q;
    logic [XLEN-1:0] pc_q, op1_q, op2_q, redirect_pc_q;
    logic [3:0]      type_q, mask_q;
    logic [4:0]      rd_q;

    logic hazard, if_ready, accept, load;
    logic slot_dep;

    // the slot's own result is not visible on any forwarding port yet
    assign slot_dep = valid_q && rd_en_q && (rd_q != 5'd0) &&
                      ((use1 && (rs1 == rd_q)) || (use2 && (rs2 == rd_q)));
    assign hazard   = (use1 && pick1[XLEN]) || (use2 && pick2[XLEN]) || slot_dep;
    assign if_ready = !hazard && (!valid_q || i_exec_ready);
    assign accept   = i_if_valid && if_ready;
    assign load     = accept && !kill_q;

    // decode
    logic [XLEN-1:0] op1_d, op2_d, target_d, ea_d;
    logic [3:0]      type_d, mask_d, alu_type;
    logic [4:0]      rd_d;
    logic            rd_en_d, sign_d, ill_d, redir_d, taken;

    always_comb begin
        case (f3)
            3'b000:  alu_type = (opc == OPC_OP && b30) ? OP_SUB : OP_ADD;
            3'b001:  alu_type = OP_SLL;
            3'b010:  alu_type = OP_SLT;
            3'b011:  alu_type = OP_SLTU;
            3'b100:  alu_type = OP_XOR;
            3'b101:  alu_type = b30 ? OP_SRA : OP_SRL;
            3'b110:  alu_type = OP_OR;
            default: alu_type = OP_AND;
        endcase
    end

    always_comb begin
        op1_d    = '0;
        op2_d    = '0;
        type_d   = OP_NOP;
        mask_d   = 4'b0000;
        rd_en_d  = 1'b0;
        sign_d   = 1'b0;
        ill_d    = 1'b0;
        redir_d  = 1'b0;
        target_d = '0;
        taken    = 1'b0;
        ea_d     = rs1_val + ((opc == OPC_STORE) ? s_imm : i_imm);
        case (opc)
            OPC_OPIMM: begin
                op1_d   = rs1_val;
                op2_d   = (f3 == 3'b001 || f3 == 3'b101) ? shamt : i_imm;
                type_d  = alu_type;
                rd_en_d = 1'b1;
            end
            OPC_OP: begin
                op1_d   = rs1_val;
                op2_d   = rs2_val;
                type_d  = alu_type;
                rd_en_d = 1'b1;
            end
            OPC_LUI: begin
                op2_d   = u_imm;
                type_d  = OP_ADD;
                rd_en_d = 1'b1;
            end
            OPC_AUIPC: begin
                op1_d   = i_if_pc;
                op2_d   = u_imm;
                type_d  = OP_ADD;
                rd_en_d = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                op1_d    = i_if_pc;
                op2_d    = XLEN'(4);
                type_d   = OP_ADD;
                rd_en_d  = 1'b1;
                redir_d  = 1'b1;
                target_d = (opc == OPC_JAL) ? (i_if_pc + j_imm) : (ea_d & ~XLEN'(1));
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  taken = (rs1_val == rs2_val);
                    3'b001:  taken = (rs1_val != rs2_val);
                    3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  taken = (rs1_val <  rs2_val);
                    3'b111:  taken = (rs1_val >= rs2_val);
                    default: ill_d = 1'b1;
                endcase
                redir_d  = taken;
                target_d = i_if_pc + b_imm;
            end
            OPC_LOAD: begin
                op2_d   = ea_d;
                type_d  = OP_LOAD;
                rd_en_d = 1'b1;
                case (f3)
                    3'b000: begin mask_d = 4'b0001; sign_d = 1'b1; end
                    3'b001: begin mask_d = 4'b0011; sign_d = 1'b1; end
                    3'b010:       mask_d = 4'b1111;
                    3'b100:       mask_d = 4'b0001;
                    3'b101:       mask_d = 4'b0011;
                    default:      ill_d  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                op1_d  = rs2_val;
                op2_d  = ea_d;
                type_d = OP_STORE;
                case (f3)
                    3'b000:  mask_d = 4'b0001;
                    3'b001:  mask_d = 4'b0011;
                    3'b010:  mask_d = 4'b1111;
                    default: ill_d  = 1'b1;
                endcase
            end
            default: ill_d = 1'b1;
        endcase
        // an illegal beat still issues, but as an inert NOP
        if (ill_d) begin
            op1_d   = '0;
            op2_d   = '0;
            type_d  = OP_NOP;
            mask_d  = 4'b0000;
            sign_d  = 1'b0;
            rd_en_d = 1'b0;
            redir_d = 1'b0;
        end
        rd_d = rd_en_d ? rd : 5'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            type_q        <= OP_NOP;
            rd_en_q       <= 1'b0;
            rd_q          <= 5'd0;
            mask_q        <= 4'b0000;
            sign_q        <= 1'b0;
            ill_q         <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            kill_q        <= RESET_PC_KILL;
        end else begin
            redirect_q <= load && redir_d;
            if (load && redir_d) begin
                redirect_pc_q <= target_d;
                kill_q        <= 1'b1;
            end else if (accept && kill_q) begin
                // wrong-path beat swallowed
                kill_q <= 1'b0;
            end
            if (load) begin
                valid_q <= 1'b1;
                pc_q    <= i_if_pc;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                type_q  <= type_d;
                rd_en_q <= rd_en_d;
                rd_q    <= rd_d;
                mask_q  <= mask_d;
                sign_q  <= sign_d;
                ill_q   <= ill_d;
            end else if (i_exec_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_if_ready       = if_ready;
    assign o_if_redirect    = redirect_q;
    assign o_if_redirect_pc = redirect_pc_q;
    assign o_exec_valid     = valid_q;
    assign o_exec_pc        = pc_q;
    assign o_exec_op1       = op1_q;
    assign o_exec_op2       = op2_q;
    assign o_exec_type      = type_q;
    assign o_exec_rd_en     = rd_en_q;
    assign o_exec_rd        = rd_q;
    assign o_exec_ram_mask  = mask_q;
    assign o_exec_sign      = sign_q;
    assign o_exec_illegal   = ill_q;

endmodule

// File: tb/tb_nnrv_id_hs.sv
// tb_nnrv_id_hs: directed vectors for nnrv_id_hs with hand-computed expectations.
// Inputs change #1 after a rising edge (or mid-cycle); outputs are sampled at #1 or on the falling edge.
// Exec backpressure is driven explicitly per scenario.
module tb_nnrv_id_hs;

    localparam int OP_NOP   = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_LOAD  = 11;
    localparam int OP_STORE = 12;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_if_valid;
    logic [31:0] i_if_instr;
    logic [31:0] i_if_pc;
    logic        o_if_ready;
    logic        o_if_redirect;
    logic [31:0] o_if_redirect_pc;
    logic [4:0]  o_reg_r1, o_reg_r2;
    logic [31:0] i_reg_r1_data, i_reg_r2_data;
    logic [1:0]  i_fwd_valid, i_fwd_ready;
    logic [9:0]  i_fwd_rd;
    logic [63:0] i_fwd_data;
    logic        o_exec_valid;
    logic        i_exec_ready;
    logic [31:0] o_exec_pc, o_exec_op1, o_exec_op2;
    logic [3:0]  o_exec_type;
    logic        o_exec_rd_en;
    logic [4:0]  o_exec_rd;
    logic [3:0]  o_exec_ram_mask;
    logic        o_exec_sign;
    logic        o_exec_illegal;

    logic [31:0] rf [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    assign i_reg_r1_data = rf[o_reg_r1];
    assign i_reg_r2_data = rf[o_reg_r2];

    nnrv_id_hs dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_if_valid       (i_if_valid),
        .i_if_instr       (i_if_instr),
        .i_if_pc          (i_if_pc),
        .o_if_ready       (o_if_ready),
        .o_if_redirect    (o_if_redirect),
        .o_if_redirect_pc (o_if_redirect_pc),
        .o_reg_r1         (o_reg_r1),
        .o_reg_r2         (o_reg_r2),
        .i_reg_r1_data    (i_reg_r1_data),
        .i_reg_r2_data    (i_reg_r2_data),
        .i_fwd_valid      (i_fwd_valid),
        .i_fwd_ready      (i_fwd_ready),
        .i_fwd_rd         (i_fwd_rd),
        .i_fwd_data       (i_fwd_data),
        .o_exec_valid     (o_exec_valid),
        .i_exec_ready     (i_exec_ready),
        .o_exec_pc        (o_exec_pc),
        .o_exec_op1       (o_exec_op1),
        .o_exec_op2       (o_exec_op2),
        .o_exec_type      (o_exec_type),
        .o_exec_rd_en     (o_exec_rd_en),
        .o_exec_rd        (o_exec_rd),
        .o_exec_ram_mask  (o_exec_ram_mask),
        .o_exec_sign      (o_exec_sign),
        .o_exec_illegal   (o_exec_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a beat, wait (bounded) for o_if_ready, let it be accepted, then
    // return #1 after the accepting edge with the beat withdrawn.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        int n;
        n = 0;
        i_if_valid = 1'b1;
        i_if_instr = instr;
        i_if_pc    = pc;
        @(negedge i_clk);
        while (!o_if_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_if_ready) check("issue_timeout", 32'(o_if_ready), 1);
        @(posedge i_clk);
        #1;
        i_if_valid = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int op1, input int op2, input int typ, input int rd);
        check({tag, "_valid"}, 32'(o_exec_valid), 1);
        check({tag, "_op1"},   o_exec_op1, op1);
        check({tag, "_op2"},   o_exec_op2, op2);
        check({tag, "_type"},  32'(o_exec_type), typ);
        check({tag, "_rd"},    32'(o_exec_rd), rd);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[3]  = 32'h33;
        rf[5]  = 32'h203;
        rf[10] = 32'hA5;
        i_rst_n      = 1'b0;
        i_fwd_valid  = 2'b00;
        i_fwd_ready  = 2'b00;
        i_fwd_rd     = 10'd0;
        i_fwd_data   = 64'd0;
        i_exec_ready = 1'b1;
        i_if_valid   = 1'b1;
        i_if_instr   = 32'h00500093;   // addi x1,x0,5
        i_if_pc      = 32'h0;

        // reset held while beats are offered
        repeat (3) @(negedge i_clk);
        check("rst_valid",    32'(o_exec_valid), 0);
        check("rst_type",     32'(o_exec_type), OP_NOP);
        check("rst_op2",      o_exec_op2, 0);
        check("rst_rd_en",    32'(o_exec_rd_en), 0);
        check("rst_redirect", 32'(o_if_redirect), 0);
        i_rst_n    = 1'b1;
        i_if_valid = 1'b0;

        // first beat after reset
        issue(32'h00500093, 32'h0);
        check_slot("addi", 0, 5, OP_ADD, 1);
        check("addi_rd_en", 32'(o_exec_rd_en), 1);

        // exec backpressure: slot holds, decode refuses
        i_exec_ready = 1'b0;
        i_if_valid   = 1'b1;
        i_if_instr   = 32'h00700113;   // addi x2,x0,7
        i_if_pc      = 32'h4;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("bp_ready", 32'(o_if_ready), 0);
            check("bp_hold",  o_exec_op2, 5);
            check("bp_valid", 32'(o_exec_valid), 1);
        end
        i_exec_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_if_valid = 1'b0;
        check_slot("bp_next", 0, 7, OP_ADD, 2);

        // forwarding priority: port 0 beats port 1 and the regfile
        i_fwd_valid = 2'b11;
        i_fwd_ready = 2'b11;
        i_fwd_rd    = {5'd3, 5'd3};
        i_fwd_data  = {32'h22, 32'h11};
        issue(32'h00318233, 32'h8);    // add x4,x3,x3
        check_slot("fwd0", 32'h11, 32'h11, OP_ADD, 4);
        i_fwd_ready = 2'b10;
        i_if_valid  = 1'b1;
        i_if_instr  = 32'h00318233;
        i_if_pc     = 32'hC;
        @(negedge i_clk);
        check("fwd_wait_ready", 32'(o_if_ready), 0);
        i_fwd_valid = 2'b10;
        issue(32'h00318233, 32'hC);
        check_slot("fwd1", 32'h22, 32'h22, OP_ADD, 4);
        i_fwd_valid = 2'b00;

        // regfile path with SUB
        issue(32'h40518333, 32'h10);   // sub x6,x3,x5
        check_slot("sub", 32'h33, 32'h203, OP_SUB, 6);

        // dependency on the occupied slot stalls one cycle
        issue(32'h00100513, 32'h14);   // addi x10,x0,1
        i_if_valid = 1'b1;
        i_if_instr = 32'h000505B3;     // add x11,x10,x0
        i_if_pc    = 32'h18;
        @(negedge i_clk);
        check("slot_haz_ready", 32'(o_if_ready), 0);
        @(negedge i_clk);
        check("slot_haz_clear", 32'(o_if_ready), 1);
        @(posedge i_clk);
        #1;
        i_if_valid = 1'b0;
        check_slot("slot_haz_add", 32'hA5, 0, OP_ADD, 11);

        // not-taken branch: no redirect
        issue(32'h00001863, 32'hF0);   // bne x0,x0,+16
        check("bne_redirect", 32'(o_if_redirect), 0);
        check("bne_rd_en",    32'(o_exec_rd_en), 0);

        // taken branch, one squashed beat, then the target issues
        issue(32'h00000863, 32'h100);  // beq x0,x0,+16
        check("beq_redirect",  32'(o_if_redirect), 1);
        check("beq_target",    o_if_redirect_pc, 32'h110);
        check("beq_type",      32'(o_exec_type), OP_NOP);
        check("beq_rd_en",     32'(o_exec_rd_en), 0);
        issue(32'h00900393, 32'h104);  // addi x7,x0,9 (wrong path)
        check("kill_valid",    32'(o_exec_valid), 0);
        check("kill_redirect", 32'(o_if_redirect), 0);
        check("kill_pc_hold",  o_if_redirect_pc, 32'h110);
        issue(32'h00300413, 32'h110);  // addi x8,x0,3
        check_slot("tgt", 0, 3, OP_ADD, 8);
        check("tgt_pc", o_exec_pc, 32'h110);

        // JALR clears bit 0 of the target
        issue(32'h004280E7, 32'h40);   // jalr x1,4(x5)
        check("jalr_redirect", 32'(o_if_redirect), 1);
        check("jalr_target",   o_if_redirect_pc, 32'h206);
        check_slot("jalr", 32'h40, 4, OP_ADD, 1);
        issue(32'h00100613, 32'h44);   // squashed
        check("jalr_kill_valid", 32'(o_exec_valid), 0);

        // load / store
        issue(32'h0082A483, 32'h200);  // lw x9,8(x5)
        check_slot("lw", 0, 32'h20B, OP_LOAD, 9);
        check("lw_mask", 32'(o_exec_ram_mask), 4'hF);
        issue(32'h003280A3, 32'h204);  // sb x3,1(x5)
        check_slot("sb", 32'h33, 32'h204, OP_STORE, 0);
        check("sb_mask",  32'(o_exec_ram_mask), 4'h1);
        check("sb_rd_en", 32'(o_exec_rd_en), 0);

        // illegal opcode, then asynchronous reset in the middle of a stall
        issue(32'h0000007F, 32'h208);
        check("ill_flag",  32'(o_exec_illegal), 1);
        check("ill_valid", 32'(o_exec_valid), 1);
        check("ill_type",  32'(o_exec_type), OP_NOP);
        check("ill_rd_en", 32'(o_exec_rd_en), 0);
        i_exec_ready = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(o_exec_valid), 0);
        check("arst_ill",    32'(o_exec_illegal), 0);
        check("arst_pc",     o_exec_pc, 0);
        check("arst_rdr_pc", o_if_redirect_pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
